// File: rtl/ttt_turn_controller.sv
// ttt_turn_controller: tic-tac-toe move sequencer and board owner.
// Optional per-turn auto-move timer is built when TTT_TIMEOUT_EN is defined.
module ttt_turn_controller #(
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int TMR_W          = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel_p,
  input  logic       confirm_p,
  input  logic       ext_valid,
  input  logic [3:0] ext_cell,
  output logic       ext_ready,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic [3:0] cursor,
  output logic       turn,
  output logic [2:0] state,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       err_p,
  output logic       timeout_p
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TURN_X = 3'd1,
    S_TURN_O = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Reject a timer too narrow to ever reach the terminal count.
  if ((64'd1 << TMR_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_tmr_w
    $error("TMR_W too narrow for TIMEOUT_CYCLES");
  end

  function automatic logic [3:0] lowest_empty(input logic [8:0] occ);
    lowest_empty = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (!occ[i]) lowest_empty = 4'(i);
    end
  endfunction

  function automatic logic [3:0] next_empty(input logic [8:0] occ,
                                            input logic [3:0] cur);
    logic found;
    int   idx;
    next_empty = cur;
    found      = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = (int'(cur) + k) % 9;
      if (!found && !occ[idx]) begin
        next_empty = 4'(idx);
        found      = 1'b1;
      end
    end
  endfunction

  function automatic logic has_line(input logic [8:0] b);
    has_line = (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) |
               (b[6] & b[7] & b[8]) | (b[0] & b[3] & b[6]) |
               (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  state_e     state_q, state_d;
  logic [8:0] bx_q, bx_d;
  logic [8:0] bo_q, bo_d;
  logic [3:0] cursor_q, cursor_d;
  logic       turn_q, turn_d;
  logic [1:0] winner_q, winner_d;
  logic       over_q, over_d;
  logic       rdy_q, rdy_d;
  logic       err_q, err_d;

  logic [8:0] occ;
  logic [8:0] mover;
  logic [3:0] low_empty;
  logic       o_ok;

  assign occ       = bx_q | bo_q;
  assign mover     = turn_q ? bo_q : bx_q;
  assign low_empty = lowest_empty(occ);
  assign o_ok      = (ext_cell <= 4'd8) && !occ[ext_cell];

`ifdef TTT_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             tmo_q, tmo_d;
  logic             in_turn;

  assign in_turn = (state_q == S_TURN_X) || (state_q == S_TURN_O);
`endif

  // Next-state, board and flag computation for the game sequencer.
  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    bo_d     = bo_q;
    cursor_d = cursor_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bx_d = '0;
        bo_d = '0;
        if (start) begin
          state_d  = S_TURN_X;
          turn_d   = 1'b0;
          cursor_d = 4'd0;
          winner_d = 2'b00;
        end
      end
      S_TURN_X: begin
        if (confirm_p) begin
          bx_d[cursor_q] = 1'b1;
          state_d        = S_CHECK;
        end else if (sel_p) begin
          cursor_d = next_empty(occ, cursor_q);
        end
      end
      S_TURN_O: begin
        if (ext_valid) begin
          if (o_ok) begin
            bo_d[ext_cell] = 1'b1;
            state_d        = S_CHECK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (has_line(mover)) begin
          winner_d = turn_q ? 2'b10 : 2'b01;
          state_d  = S_DONE;
        end else if (&occ) begin
          winner_d = 2'b11;
          state_d  = S_DONE;
        end else begin
          turn_d = ~turn_q;
          if (turn_q) begin
            state_d  = S_TURN_X;
            cursor_d = low_empty;
          end else begin
            state_d = S_TURN_O;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          bx_d     = '0;
          bo_d     = '0;
          winner_d = 2'b00;
          turn_d   = 1'b0;
          cursor_d = 4'd0;
          state_d  = S_TURN_X;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef TTT_TIMEOUT_EN
    tmo_d = 1'b0;
    if (in_turn && (state_d == state_q) && (timer_q == TMO_LAST)) begin
      if (turn_q) bo_d[low_empty] = 1'b1;
      else        bx_d[low_empty] = 1'b1;
      tmo_d   = 1'b1;
      state_d = S_CHECK;
    end
    if (in_turn && (state_d == state_q)) timer_d = timer_q + TMR_ONE;
    else                                 timer_d = '0;
`endif

    rdy_d  = (state_d == S_TURN_O);
    over_d = (state_d == S_DONE);
  end

  // Register all state and outputs; reset drops any in-flight commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bx_q     <= '0;
      bo_q     <= '0;
      cursor_q <= 4'd0;
      turn_q   <= 1'b0;
      winner_q <= 2'b00;
      over_q   <= 1'b0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef TTT_TIMEOUT_EN
      timer_q  <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      bo_q     <= bo_d;
      cursor_q <= cursor_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      over_q   <= over_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
`ifdef TTT_TIMEOUT_EN
      timer_q  <= timer_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign ext_ready = rdy_q;
  assign board_x   = bx_q;
  assign board_o   = bo_q;
  assign cursor    = cursor_q;
  assign turn      = turn_q;
  assign state     = state_q;
  assign winner    = winner_q;
  assign game_over = over_q;
  assign err_p     = err_q;
`ifdef TTT_TIMEOUT_EN
  assign timeout_p = tmo_q;
`else
  assign timeout_p = 1'b0;
`endif

endmodule

// File: tb/tb_ttt_turn_controller.sv
// tb_ttt_turn_controller: self-checking bench for the turn controller.
// Game-level reference model (cell array, line table) drives expectations.
module tb_ttt_turn_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sel_p = 1'b0;
  logic       confirm_p = 1'b0;
  logic       ext_valid = 1'b0;
  logic [3:0] ext_cell = 4'd0;
  logic       ext_ready;
  logic [8:0] board_x, board_o;
  logic [3:0] cursor;
  logic       turn;
  logic [2:0] state;
  logic [1:0] winner;
  logic       game_over, err_p, timeout_p;

  ttt_turn_controller #(
    .TIMEOUT_CYCLES(16),
    .TMR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sel_p(sel_p),
    .confirm_p(confirm_p), .ext_valid(ext_valid), .ext_cell(ext_cell),
    .ext_ready(ext_ready), .board_x(board_x), .board_o(board_o),
    .cursor(cursor), .turn(turn), .state(state), .winner(winner),
    .game_over(game_over), .err_p(err_p), .timeout_p(timeout_p)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 empty, 1 X, 2 O.
  int cells [9];
  int m_turn;
  int m_cursor;
  int m_winner;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit m_line(int p);
    for (int i = 0; i < 8; i++)
      if (cells[lines[i][0]] == p && cells[lines[i][1]] == p &&
          cells[lines[i][2]] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < 9; i++) if (cells[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < 9; i++) if (cells[i] == 0) return i;
    return 0;
  endfunction

  function automatic int m_next(int c);
    for (int k = 1; k <= 8; k++)
      if (cells[(c + k) % 9] == 0) return (c + k) % 9;
    return c;
  endfunction

  function automatic logic [8:0] m_b(int p);
    logic [8:0] v = '0;
    for (int i = 0; i < 9; i++) if (cells[i] == p) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [2:0] m_state();
    if (m_winner != 0) return 3'd4;
    return m_turn != 0 ? 3'd2 : 3'd1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 9; i++) cells[i] = 0;
    m_turn = 0; m_cursor = 0; m_winner = 0;
  endtask

  task automatic judge(int p);
    if (m_line(p)) m_winner = p;
    else if (m_full()) m_winner = 3;
    else begin
      m_turn = 1 - m_turn;
      if (m_turn == 0) m_cursor = m_lowest();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    m_clear();
  endtask

  task automatic new_game();
    start = 1'b1; tick(); start = 1'b0;
    m_clear();
  endtask

  task automatic x_goto(int target);
    for (int n = 0; n < 9; n++) begin
      if (m_cursor == target) break;
      sel_p = 1'b1; tick(); sel_p = 1'b0;
      m_cursor = m_next(m_cursor);
    end
  endtask

  task automatic x_commit();
    confirm_p = 1'b1; tick(); confirm_p = 1'b0;
    cells[m_cursor] = 1;
    tick();
    judge(1);
  endtask

  task automatic o_commit(int c);
    ext_valid = 1'b1; ext_cell = 4'(c); tick(); ext_valid = 1'b0;
    cells[c] = 2;
    tick();
    judge(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++;
    if ({state, board_x, board_o, cursor, turn, winner, game_over,
         ext_ready, err_p, timeout_p} !== 32'd0) begin
      errors++;
      $display("FAIL reset_vals st=%0d bx=%h bo=%h cur=%0d w=%0d rdy=%0d want all 0",
               state, board_x, board_o, cursor, winner, ext_ready);
    end
    tick();
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL idle_hold st=%0d want 0", state);
    end
    m_clear();
  endtask

  task automatic test_first_moves();
    logic [3:0] want;
    new_game();
    checks++;
    if ({state, cursor, board_x, board_o} !== {3'd1, 4'd0, 18'd0}) begin
      errors++;
      $display("FAIL start st=%0d cur=%0d bx=%h bo=%h want 1 0 0 0",
               state, cursor, board_x, board_o);
    end
    for (int i = 1; i <= 3; i++) begin
      sel_p = 1'b1; tick(); sel_p = 1'b0;
      want = 4'(i);
      checks++;
      if (cursor !== want) begin
        errors++; $display("FAIL sel_step cur=%0d want %0d", cursor, want);
      end
    end
    confirm_p = 1'b1; tick(); confirm_p = 1'b0;
    checks++;
    if ({board_x, state, ext_ready} !== {9'h008, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL x_commit_n1 bx=%h st=%0d rdy=%0d want 008 3 0",
               board_x, state, ext_ready);
    end
    tick();
    checks++;
    if ({state, turn, ext_ready} !== {3'd2, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL x_commit_n2 st=%0d turn=%0d rdy=%0d want 2 1 1",
               state, turn, ext_ready);
    end
  endtask

  task automatic test_x_win();
    hard_reset(); new_game();
    x_commit(); o_commit(3);
    x_goto(1); x_commit(); o_commit(4);
    x_goto(2); x_commit();
    checks++;
    if ({winner, game_over, state, board_x, board_o} !==
        {2'b01, 1'b1, 3'd4, 9'h007, 9'h018}) begin
      errors++;
      $display("FAIL x_win w=%0d go=%0d st=%0d bx=%h bo=%h want 1 1 4 007 018",
               winner, game_over, state, board_x, board_o);
    end
    ext_valid = 1'b1; ext_cell = 4'd5; tick();
    checks++;
    if ({ext_ready, board_o, state} !== {1'b0, 9'h018, 3'd4}) begin
      errors++;
      $display("FAIL done_ext rdy=%0d bo=%h st=%0d want 0 018 4",
               ext_ready, board_o, state);
    end
    ext_valid = 1'b0; tick();
  endtask

  task automatic test_o_reject();
    new_game();
    checks++;
    if ({board_x, board_o, winner, state, game_over, turn} !==
        {18'd0, 2'b00, 3'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL restart bx=%h bo=%h w=%0d st=%0d go=%0d want clear TURN_X",
               board_x, board_o, winner, state, game_over);
    end
    x_commit();
    ext_valid = 1'b1; ext_cell = 4'd0; tick(); ext_valid = 1'b0;
    checks++;
    if ({err_p, state, board_x, board_o} !== {1'b1, 3'd2, 9'h001, 9'h000}) begin
      errors++;
      $display("FAIL rej_occ err=%0d st=%0d bx=%h bo=%h want 1 2 001 000",
               err_p, state, board_x, board_o);
    end
    tick();
    checks++;
    if (err_p !== 1'b0) begin
      errors++; $display("FAIL err_width err=%0d want 0", err_p);
    end
    ext_valid = 1'b1; ext_cell = 4'd9; tick(); ext_valid = 1'b0;
    checks++;
    if ({err_p, state, board_o} !== {1'b1, 3'd2, 9'h000}) begin
      errors++;
      $display("FAIL rej_range err=%0d st=%0d bo=%h want 1 2 000",
               err_p, state, board_o);
    end
    tick();
    ext_valid = 1'b1; ext_cell = 4'd5; tick(); ext_valid = 1'b0;
    checks++;
    if ({err_p, state, board_o, ext_ready} !== {1'b0, 3'd3, 9'h020, 1'b0}) begin
      errors++;
      $display("FAIL o_accept err=%0d st=%0d bo=%h rdy=%0d want 0 3 020 0",
               err_p, state, board_o, ext_ready);
    end
    tick();
  endtask

  task automatic test_cursor_walk();
    logic [3:0] walk [5] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd4};
    hard_reset(); new_game();
    x_commit(); o_commit(1);
    x_goto(2); x_commit(); o_commit(3);
    checks++;
    if ({state, cursor} !== {3'd1, 4'd4}) begin
      errors++;
      $display("FAIL cur_load st=%0d cur=%0d want 1 4", state, cursor);
    end
    for (int i = 0; i < 5; i++) begin
      sel_p = 1'b1; tick(); sel_p = 1'b0;
      checks++;
      if (cursor !== walk[i]) begin
        errors++;
        $display("FAIL cur_walk step=%0d cur=%0d want %0d", i, cursor, walk[i]);
      end
    end
    sel_p = 1'b1; confirm_p = 1'b1; tick(); sel_p = 1'b0; confirm_p = 1'b0;
    checks++;
    if ({board_x, state} !== {9'h015, 3'd3}) begin
      errors++;
      $display("FAIL sel_conf bx=%h st=%0d want 015 3", board_x, state);
    end
    tick();
  endtask

  task automatic test_draw();
    int seq [9] = '{0, 2, 1, 3, 5, 4, 6, 7, 8};
    hard_reset(); new_game();
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) begin x_goto(seq[i]); x_commit(); end
      else o_commit(seq[i]);
      checks++;
      if ({state, winner, board_x, board_o} !==
          {m_state(), 2'(m_winner), m_b(1), m_b(2)}) begin
        errors++;
        $display("FAIL draw_mv%0d st=%0d w=%0d bx=%h bo=%h want %0d %0d %h %h",
                 i, state, winner, board_x, board_o,
                 m_state(), m_winner, m_b(1), m_b(2));
      end
    end
    checks++;
    if ({winner, game_over} !== {2'b11, 1'b1}) begin
      errors++;
      $display("FAIL draw w=%0d go=%0d want 3 1", winner, game_over);
    end
  endtask

  task automatic test_rst_mid();
    hard_reset(); new_game(); x_commit();
    ext_valid = 1'b1; ext_cell = 4'd4; rst = 1'b1; tick();
    rst = 1'b0; ext_valid = 1'b0;
    checks++;
    if ({state, board_x, board_o, cursor, turn, winner, game_over,
         ext_ready, err_p, timeout_p} !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid st=%0d bx=%h bo=%h rdy=%0d want all 0",
               state, board_x, board_o, ext_ready);
    end
    tick();
    checks++;
    if ({state, board_o} !== {3'd0, 9'h000}) begin
      errors++;
      $display("FAIL rst_discard st=%0d bo=%h want 0 000", state, board_o);
    end
    m_clear();
  endtask

  task automatic test_random();
    int k, c, tries;
    int q[$];
    hard_reset();
    for (int g = 0; g < 25; g++) begin
      new_game();
      for (int mv = 0; mv < 12 && m_winner == 0; mv++) begin
        if (m_turn == 0) begin
          checks++;
          if ({state, cursor} !== {3'd1, 4'(m_cursor)}) begin
            errors++;
            $display("FAIL rnd_xturn st=%0d cur=%0d want 1 %0d",
                     state, cursor, m_cursor);
          end
          k = $urandom_range(0, 3);
          for (int s = 0; s < k; s++) begin
            sel_p = 1'b1; start = 1'($urandom_range(0, 1)); tick();
            sel_p = 1'b0; start = 1'b0;
            m_cursor = m_next(m_cursor);
            checks++;
            if ({state, cursor} !== {3'd1, 4'(m_cursor)}) begin
              errors++;
              $display("FAIL rnd_sel st=%0d cur=%0d want 1 %0d",
                       state, cursor, m_cursor);
            end
          end
          sel_p = ($urandom_range(0, 2) == 0); confirm_p = 1'b1; tick();
          sel_p = 1'b0; confirm_p = 1'b0;
          cells[m_cursor] = 1;
          checks++;
          if ({state, board_x, board_o, ext_ready} !==
              {3'd3, m_b(1), m_b(2), 1'b0}) begin
            errors++;
            $display("FAIL rnd_xc st=%0d bx=%h bo=%h want 3 %h %h",
                     state, board_x, board_o, m_b(1), m_b(2));
          end
          tick(); judge(1);
        end else begin
          tries = $urandom_range(0, 2);
          for (int a = 0; a < 4; a++) begin
            c = $urandom_range(0, 11);
            if (a >= tries && !(c <= 8 && cells[c] == 0)) begin
              q.delete();
              for (int i = 0; i < 9; i++) if (cells[i] == 0) q.push_back(i);
              c = q[$urandom_range(0, q.size() - 1)];
            end
            ext_valid = 1'b1; ext_cell = 4'(c); tick(); ext_valid = 1'b0;
            if (c <= 8 && cells[c] == 0) begin
              cells[c] = 2;
              checks++;
              if ({state, err_p, board_x, board_o} !==
                  {3'd3, 1'b0, m_b(1), m_b(2)}) begin
                errors++;
                $display("FAIL rnd_oc st=%0d err=%0d bo=%h want 3 0 %h",
                         state, err_p, board_o, m_b(2));
              end
              tick(); judge(2);
              break;
            end
            checks++;
            if ({state, err_p, board_x, board_o} !==
                {3'd2, 1'b1, m_b(1), m_b(2)}) begin
              errors++;
              $display("FAIL rnd_orej cell=%0d st=%0d err=%0d bo=%h want 2 1 %h",
                       c, state, err_p, board_o, m_b(2));
            end
            tick();
          end
        end
        checks++;
        if ({state, winner, game_over} !==
            {m_state(), 2'(m_winner), m_winner != 0}) begin
          errors++;
          $display("FAIL rnd_post st=%0d w=%0d go=%0d want %0d %0d",
                   state, winner, game_over, m_state(), m_winner);
        end
        if (m_winner == 0) begin
          checks++;
          if (turn !== 1'(m_turn) || ext_ready !== 1'(m_turn)) begin
            errors++;
            $display("FAIL rnd_turn turn=%0d rdy=%0d want %0d",
                     turn, ext_ready, m_turn);
          end
        end
      end
    end
  endtask

`ifdef TTT_TIMEOUT_EN
  task automatic test_timeout();
    hard_reset(); new_game();
    repeat (15) tick();
    checks++;
    if ({state, timeout_p, board_x} !== {3'd1, 1'b0, 9'h000}) begin
      errors++;
      $display("FAIL tmo_early st=%0d tmo=%0d bx=%h want 1 0 000",
               state, timeout_p, board_x);
    end
    tick();
    checks++;
    if ({timeout_p, board_x, state} !== {1'b1, 9'h001, 3'd3}) begin
      errors++;
      $display("FAIL tmo_x tmo=%0d bx=%h st=%0d want 1 001 3",
               timeout_p, board_x, state);
    end
    tick();
    checks++;
    if ({timeout_p, state} !== {1'b0, 3'd2}) begin
      errors++;
      $display("FAIL tmo_pulse tmo=%0d st=%0d want 0 2", timeout_p, state);
    end
    repeat (16) tick();
    checks++;
    if ({timeout_p, board_o, state} !== {1'b1, 9'h002, 3'd3}) begin
      errors++;
      $display("FAIL tmo_o tmo=%0d bo=%h st=%0d want 1 002 3",
               timeout_p, board_o, state);
    end
    tick();
    repeat (15) tick();
    confirm_p = 1'b1; tick(); confirm_p = 1'b0;
    checks++;
    if ({timeout_p, board_x, state} !== {1'b0, 9'h005, 3'd3}) begin
      errors++;
      $display("FAIL tmo_race tmo=%0d bx=%h st=%0d want 0 005 3",
               timeout_p, board_x, state);
    end
    tick();
  endtask
`else
  task automatic test_timeout();
    hard_reset(); new_game();
    repeat (40) tick();
    checks++;
    if ({state, timeout_p, board_x} !== {3'd1, 1'b0, 9'h000}) begin
      errors++;
      $display("FAIL no_tmo st=%0d tmo=%0d bx=%h want 1 0 000",
               state, timeout_p, board_x);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_moves();
    test_x_win();
    test_o_reject();
    test_cursor_walk();
    test_draw();
    test_rst_mid();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttt_turn_controller.md
# ttt_turn_controller

Game sequencer for the tic-tac-toe board. It owns the two 9-cell occupancy registers (X and O) and hands move rights alternately to a local player (debounced push-buttons, X) and an external requester (valid/ready port, O). It validates every move, checks for a win or draw after each commit, and drives the board vectors consumed by the VGA board renderer and the top-level screen FSM.

## Interface
Parameters:
- TIMEOUT_CYCLES, 500_000_000: per-turn time limit in clk cycles (10 s at 50 MHz). Used only with TTT_TIMEOUT_EN.
- TMR_W, 32: timer counter width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new game from IDLE or DONE.
- sel_p  in  1  single-cycle debounced pulse; moves the X cursor.
- confirm_p  in  1  single-cycle debounced pulse; commits X at the cursor.
- ext_valid  in  1  external O move request.
- ext_cell  in  4  requested cell index, 0..8, row-major.
- ext_ready  out  1  O move accepted this cycle when ext_valid is also high.
- board_x  out  9  bit i set means cell i holds X.
- board_o  out  9  bit i set means cell i holds O.
- cursor  out  4  current X selection, 0..8.
- turn  out  1  0 = X to move, 1 = O to move.
- state  out  3  FSM state encoding.
- winner  out  2  00 none, 01 X, 10 O, 11 draw.
- game_over  out  1  high in DONE.
- err_p  out  1  one-cycle pulse when an O request is rejected.
- timeout_p  out  1  one-cycle pulse when the controller makes an automatic move.

## Operation
- States and encodings: IDLE=0, TURN_X=1, TURN_O=2, CHECK=3, DONE=4.
- IDLE: board is held clear. start moves the FSM to TURN_X with turn=0 and cursor=0.
- TURN_X:
  - The cursor always points to an empty cell.
  - sel_p advances the cursor to the next empty cell in ascending index, wrapping 8 to 0.
  - confirm_p sets board_x[cursor] and goes to CHECK.
  - If sel_p and confirm_p arrive together, confirm wins and sel is ignored.
  - ext_valid is ignored and ext_ready=0.
- TURN_O:
  - ext_ready=1 every cycle.
  - On ext_valid, if ext_cell ≤ 8 and the cell is empty in both board_x and board_o: set board_o[ext_cell] and go to CHECK.
  - Otherwise pulse err_p for one cycle and stay in TURN_O.
  - sel_p and confirm_p are ignored.
- CHECK (one cycle):
  - Evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) for the player who just moved.
  - Win: set winner to 01 or 10 and go to DONE.
  - All 9 cells occupied with no win: set winner=11 and go to DONE.
  - Otherwise toggle turn and go to TURN_O or TURN_X. On entry to TURN_X, cursor is loaded with the lowest-index empty cell.
- DONE:
  - game_over=1; board and winner are held.
  - start clears the board, sets winner=00 and turn=0, and goes to TURN_X with cursor=0.
- start is ignored in TURN_X, TURN_O and CHECK.
- Reset values: board_x=0, board_o=0, cursor=0, turn=0, state=IDLE, winner=00, game_over=0, ext_ready=0, err_p=0, timeout_p=0. Internal timer=0.

## Timing
- All outputs are registered.
- Commit latency:
  - Move sampled at edge N.
  - board_x/board_o updated and state=CHECK from N+1.
  - From N+2: state=TURN_X/TURN_O/DONE; winner, game_over, turn and cursor valid.
- O handshake: transfer occurs on the edge where ext_valid && ext_ready. ext_ready drops in the CHECK cycle. err_p is asserted in cycle N+1 after a rejected request at N.
- sel_p: the cursor updates one cycle after the pulse.
- rst asserted in any state: all outputs take reset values at the next edge, and any in-flight commit is discarded.

## Configuration
- TTT_TIMEOUT_EN defined:
  - The turn timer counts every cycle in TURN_X/TURN_O and clears on entry to either state.
  - When it reaches TIMEOUT_CYCLES-1 with no commit that cycle, the controller commits the lowest empty cell for the current player, pulses timeout_p, and goes to CHECK.
  - If a player commit and the expiry fall in the same cycle, the player commit wins and timeout_p stays low.
- TTT_TIMEOUT_EN undefined: no timer logic is built, turns wait indefinitely, and timeout_p is tied to 0.

## Test plan
- Reset then start: state=1, cursor=0, boards 0. Three sel_p pulses give cursor=3. confirm_p gives board_x=9'h008 at N+1 and state=2, turn=1 at N+2.
- X plays cells 0, 1, 2; O plays 3 and 4 via ext_valid/ext_cell. After X's third commit: winner=01, game_over=1, state=4. Further ext_valid leaves ext_ready=0.
- In TURN_O with board_x=9'h001: ext_cell=0 pulses err_p and leaves boards unchanged. ext_cell=9 pulses err_p. ext_cell=5 is accepted and gives board_o=9'h020.
- Board with cells 0..3 full, X to move: cursor loads 4. sel_p walks 5,6,7,8 then wraps to 4, skipping occupied cells. sel_p and confirm_p in the same cycle commit cell 4.
- Draw sequence X:0,1,5,6,8 and O:2,3,4,7: after the final commit winner=11. rst asserted mid-game in TURN_O returns all outputs to reset values the next cycle.
- With TTT_TIMEOUT_EN and TIMEOUT_CYCLES=16: no input in TURN_X for 16 cycles gives timeout_p=1 and board_x bit for the lowest empty cell. A confirm on cycle 15 gives a normal commit with no timeout_p.
